// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the word PC, drives a req/ack imem and resolves
// ID/EX redirects with delay-slot semantics. Define FETCH_PERF_EN to add the performance counters.
module fetch_seq_ctrl #(
  parameter int          PC_W     = 30,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            if_stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            jr_valid,
  input  logic [PC_W-1:0] jr_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic            if_valid,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic [1:0]      state_o,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     squash_cnt,
  output logic [31:0]     stall_cnt
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_REDIR = 2'd3;

  localparam logic [PC_W-1:0] L_RESET_PC = PC_W'(RESET_PC);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pend_target;
  logic            r_pend_keep;

  logic            w_redir_ex;
  logic [PC_W-1:0] w_ex_target;
  logic            w_if_valid;
  logic            w_squash;

  assign w_redir_ex  = br_valid | jr_valid;
  assign w_ex_target = br_valid ? br_target : jr_target;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_if_valid = 1'b0;
    w_squash   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_if_valid = imem_ack & ~w_redir_ex & ~if_stall;
        w_squash   = imem_ack & w_redir_ex;
      end
      S_REDIR: begin
        w_if_valid = imem_ack & r_pend_keep & ~w_redir_ex & ~if_stall;
        w_squash   = imem_ack & (w_redir_ex | ~r_pend_keep);
      end
      default: ;
    endcase
  end

  assign imem_req  = (r_state == S_FETCH) || (r_state == S_REDIR);
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  // Forced to zero while in RESET so every non-address output reads 0 there.
  assign pc_plus1  = (r_state == S_RESET) ? '0 : r_pc + 1'b1;
  assign if_valid  = w_if_valid;
  assign state_o   = r_state;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_pc          <= L_RESET_PC;
      r_pend_target <= '0;
      r_pend_keep   <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            if (w_redir_ex) begin
              r_pc <= w_ex_target;
            end else if (if_stall) begin
              // A stalled delay slot is parked with its jump so HOLD can re-fetch it.
              r_state <= S_HOLD;
              if (jmp_valid) begin
                r_pend_target <= jmp_target;
                r_pend_keep   <= 1'b1;
              end
            end else if (jmp_valid) begin
              r_pc <= jmp_target;
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end else if (w_redir_ex) begin
            r_pend_target <= w_ex_target;
            r_pend_keep   <= 1'b0;
            r_state       <= S_REDIR;
          end else if (jmp_valid) begin
            r_pend_target <= jmp_target;
            r_pend_keep   <= 1'b1;
            r_state       <= S_REDIR;
          end
        end
        S_HOLD: begin
          if (w_redir_ex) begin
            r_pc        <= w_ex_target;
            r_pend_keep <= 1'b0;
            r_state     <= S_FETCH;
          end else if (jmp_valid) begin
            r_pend_target <= jmp_target;
            r_pend_keep   <= 1'b1;
            r_state       <= S_REDIR;
          end else if (!if_stall) begin
            r_state <= r_pend_keep ? S_REDIR : S_FETCH;
          end
        end
        default: begin
          if (imem_ack) begin
            if (w_redir_ex) begin
              r_pc        <= w_ex_target;
              r_pend_keep <= 1'b0;
              r_state     <= S_FETCH;
            end else if (r_pend_keep && if_stall) begin
              r_state <= S_HOLD;
            end else begin
              r_pc        <= r_pend_target;
              r_pend_keep <= 1'b0;
              r_state     <= S_FETCH;
            end
          end else if (w_redir_ex) begin
            r_pend_target <= w_ex_target;
            r_pend_keep   <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_squash_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_if_valid)         r_fetch_cnt  <= r_fetch_cnt + 1'b1;
      if (w_squash)           r_squash_cnt <= r_squash_cnt + 1'b1;
      if (r_state == S_HOLD)  r_stall_cnt  <= r_stall_cnt + 1'b1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign squash_cnt = r_squash_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign fetch_cnt  = '0;
  assign squash_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule
